// File: rtl/io_uart_tx_bridge_if.sv
// IO-pin bundle between the microcontroller ports and the UART TX bridge.
// port0Val carries the firmware's send toggle, overflow clear and data byte;
// port1Val returns the status word; txd is the serial line.
interface io_uart_tx_bridge_if;
  logic [15:0] port0Val;
  logic [15:0] port1Val;
  logic        txd;

  modport master (
    output port0Val,
    input  port1Val,
    input  txd
  );

  modport slave (
    input  port0Val,
    output port1Val,
    output txd
  );
endinterface

// File: rtl/io_uart_tx_bridge.sv
// UART transmit bridge: takes bytes from port 0 with a toggle handshake,
// queues them in a small FIFO and sends them as 8N1 frames on txd.
// Firmware polls busy/full/overflow/count/ack through port 1.
module io_uart_tx_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input logic                clk,
  input logic                reset,
  io_uart_tx_bridge_if.slave bus
);

  localparam int          PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] DIV_LAST   = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  COUNT_FULL = 3'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txStateT;

  // Handshake and FIFO state
  logic             lastTog;
  logic [7:0]       fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [2:0]       count;
  logic             overflow;

  // Serialiser state
  txStateT     state;
  txStateT     stateNext;
  logic [15:0] divCnt;
  logic [15:0] divNext;
  logic [2:0]  bitIdx;
  logic [2:0]  bitIdxNext;
  logic [7:0]  shiftReg;
  logic [7:0]  shiftNext;
  logic        txdReg;
  logic        txdNext;
  logic [15:0] port1Reg;

  logic pushReq;
  logic popReq;
  logic pushAcc;
  logic pushRej;
  logic divDone;
  logic busy;
  logic full;

  // Bits [13:8] of the port-0 word carry nothing for this block.
  logic [5:0] unusedPort0Bits;
  assign unusedPort0Bits = bus.port0Val[13:8];

  // A push is any change of the toggle bit; it may land on the same edge the
  // serialiser pops, which frees the slot it needs even when the FIFO is full.
  assign pushReq = bus.port0Val[15] != lastTog;
  assign popReq  = (state == IDLE) && (count != 3'd0);
  assign pushAcc = pushReq && ((count < COUNT_FULL) || popReq);
  assign pushRej = pushReq && !pushAcc;
  assign divDone = divCnt == DIV_LAST;
  assign busy    = (state != IDLE) || (count != 3'd0);
  assign full    = count == COUNT_FULL;

  assign bus.port1Val = port1Reg;
  assign bus.txd      = txdReg;

  // Next-state logic for the frame serialiser, plus the txd level for that state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    stateNext  = state;
    divNext    = divCnt;
    bitIdxNext = bitIdx;
    shiftNext  = shiftReg;
    txdNext    = 1'b1;
    case (state)
      IDLE: begin
        if (popReq) begin
          stateNext = START;
          divNext   = '0;
          shiftNext = fifoMem[rdPtr];
        end
      end
      START: begin
        if (divDone) begin
          stateNext  = DATA;
          bitIdxNext = '0;
          divNext    = '0;
        end else begin
          divNext = divCnt + 16'd1;
        end
      end
      DATA: begin
        if (divDone) begin
          divNext = '0;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
          end
        end else begin
          divNext = divCnt + 16'd1;
        end
      end
      STOP: begin
        if (divDone) begin
          stateNext = IDLE;
          divNext   = '0;
        end else begin
          divNext = divCnt + 16'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
    // txd is registered from the state being entered so the line is glitch-free.
    case (stateNext)
      START:   txdNext = 1'b0;
      DATA:    txdNext = shiftNext[bitIdxNext];
      default: txdNext = 1'b1;
    endcase
  end

  // Control registers: handshake, FIFO pointers/count, overflow, serialiser, status.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    if (!reset) begin
      lastTog  <= 1'b0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      state    <= IDLE;
      divCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txdReg   <= 1'b1;
      port1Reg <= '0;
    end else begin
      if (pushReq) lastTog <= bus.port0Val[15];
      if (pushAcc) wrPtr <= wrPtr + 1'b1;
      if (popReq)  rdPtr <= rdPtr + 1'b1;
      case ({pushAcc, popReq})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // A rejected push in the same cycle as a clear leaves the flag set.
      if (pushRej) begin
        overflow <= 1'b1;
      end else if (bus.port0Val[14]) begin
        overflow <= 1'b0;
      end
      state    <= stateNext;
      divCnt   <= divNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftNext;
      txdReg   <= txdNext;
      port1Reg <= {lastTog, 9'b0, count, overflow, full, busy};
    end
  end

  // Byte storage; only the write pointer and count decide which entries are live.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; stale entries are never read because
    // the count gates every pop.
    if (reset && pushAcc) fifoMem[wrPtr] <= bus.port0Val[7:0];
  end

endmodule

// File: tb/tb_io_uart_tx_bridge.sv
// Directed bench for io_uart_tx_bridge. Stimulus pushes the bytes it expects
// on txd into a queue; a monitor decodes every frame and compares.
module tb_io_uart_tx_bridge;
  localparam int CPB = 4;

  logic clk;
  logic reset;
  io_uart_tx_bridge_if bus ();

  io_uart_tx_bridge #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int         checks     = 0;
  int         errors     = 0;
  int         cycleCnt   = 0;
  int         abortCount = 0;
  logic [7:0] expQ[$];
  int         frameStarts[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame monitor: on a falling txd, pops the expected byte and checks every
  // cycle of the 10-bit frame; a reset mid-frame abandons the comparison.
  initial begin : monitor
    logic [9:0] frame;
    logic [7:0] got;
    logic [7:0] exp;
    bit         bad;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.txd === 1'b0) begin
        frameStarts.push_back(cycleCnt);
        if (expQ.size() != 0) begin
          exp = expQ.pop_front();
        end else begin
          exp = 8'h00;
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got a frame, expected queue is empty");
        end
        frame   = {1'b1, exp, 1'b0};
        got     = 8'h00;
        bad     = 1'b0;
        aborted = 1'b0;
        for (int c = 0; c < 10 * CPB; c++) begin
          if (c > 0) @(negedge clk);
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (bus.txd !== frame[c / CPB]) bad = 1'b1;
          if ((c % CPB == CPB / 2) && (c / CPB >= 1) && (c / CPB <= 8))
            got[c / CPB - 1] = bus.txd;
        end
        if (aborted) begin
          abortCount++;
        end else begin
          check("frame_byte", 16'(got), 16'(exp));
          check("frame_timing", 16'(bad), 16'h0000);
        end
      end
    end
  end

  initial begin : stimulus
    reset        = 1'b0;
    bus.port0Val = 16'hFFFF;
    tick(3);
    check("rst_status", bus.port1Val, 16'h0000);
    check("rst_txd", 16'(bus.txd), 16'h0001);

    reset        = 1'b1;
    bus.port0Val = 16'h0000;
    tick(2);
    check("release_status", bus.port1Val, 16'h0000);
    check("release_txd", 16'(bus.txd), 16'h0001);

    // Single byte A5: queued at edge N, start bit after N+1, busy clears after N+42.
    bus.port0Val = 16'h80A5;
    expQ.push_back(8'hA5);
    tick(1);
    check("a5_txd_still_idle", 16'(bus.txd), 16'h0001);
    tick(1);
    check("a5_status_queued", bus.port1Val, 16'h8009);
    check("a5_txd_start", 16'(bus.txd), 16'h0000);
    tick(1);
    check("a5_status_sending", bus.port1Val, 16'h8001);
    tick(39);
    check("a5_busy_in_stop", bus.port1Val, 16'h8001);
    tick(1);
    check("a5_idle", bus.port1Val, 16'h8000);

    // Fill: 3C starts sending, 01..04 fill the FIFO, 05 overflows.
    bus.port0Val = 16'h003C;
    expQ.push_back(8'h3C);
    tick(2);
    bus.port0Val = 16'h8001; expQ.push_back(8'h01); tick(1);
    bus.port0Val = 16'h0002; expQ.push_back(8'h02); tick(1);
    bus.port0Val = 16'h8003; expQ.push_back(8'h03); tick(1);
    bus.port0Val = 16'h0004; expQ.push_back(8'h04); tick(1);
    bus.port0Val = 16'h8005; tick(1);
    check("fill_full", bus.port1Val, 16'h0023);
    tick(1);
    check("fill_overflow", bus.port1Val, 16'h8027);

    // Overflow clear, then clear together with a rejected push.
    bus.port0Val = 16'hC005; tick(1);
    bus.port0Val = 16'h8005; tick(1);
    check("ovf_cleared", bus.port1Val, 16'h8023);
    bus.port0Val = 16'h4006; tick(1);
    bus.port0Val = 16'h0006; tick(1);
    check("ovf_set_wins", bus.port1Val, 16'h0027);
    bus.port0Val = 16'h4006; tick(1);
    bus.port0Val = 16'h0006; tick(1);
    check("ovf_cleared_again", bus.port1Val, 16'h0023);

    // Push on the exact edge IDLE pops 01 with the FIFO full.
    tick(28);
    bus.port0Val = 16'h8007;
    expQ.push_back(8'h07);
    tick(1);
    tick(1);
    check("push_pop_same_edge", bus.port1Val, 16'h8023);

    // Drain 01,02,03,04,07 back to back.
    tick(206);
    check("drain_idle", bus.port1Val, 16'h8000);
    check("drain_queue_empty", 16'(expQ.size()), 16'h0000);

    // Reset during DATA bit 3 of C3 (bit 3 of C3 is 0).
    bus.port0Val = 16'h00C3;
    expQ.push_back(8'hC3);
    tick(19);
    check("c3_bit3_low", 16'(bus.txd), 16'h0000);
    reset = 1'b0;
    tick(1);
    check("midreset_txd", 16'(bus.txd), 16'h0001);
    check("midreset_status", bus.port1Val, 16'h0000);
    reset = 1'b1;
    tick(3);
    check("no_spurious_status", bus.port1Val, 16'h0000);
    check("no_spurious_txd", 16'(bus.txd), 16'h0001);

    // Recovery frame after reset.
    bus.port0Val = 16'h805A;
    expQ.push_back(8'h5A);
    tick(45);
    check("recover_idle", bus.port1Val, 16'h8000);
    check("final_queue_empty", 16'(expQ.size()), 16'h0000);
    check("abort_count", 16'(abortCount), 16'h0001);
    check("frame_count", 16'(frameStarts.size()), 16'd9);
    if (frameStarts.size() >= 7) begin
      for (int k = 1; k <= 5; k++)
        check("frame_gap", 16'(frameStarts[k + 1] - frameStarts[k]), 16'd41);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_uart_tx_bridge.md
Name: io_uart_tx_bridge

Overview:
- Peripheral on the microcontroller's IO pins: consumes the 16-bit port-0 output word, queues bytes in a 4-entry FIFO and serialises them as 8N1 UART frames on txd.
- Produces the 16-bit status word that drives the port-1 input, so firmware polls busy/full/overflow through port 1 and hands off bytes through port 0 with a toggle handshake.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte FIFO entries; fixed power of two, count field is 3 bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- port0Val  input  16  port-0 word: [15] send toggle, [14] overflow clear (level), [7:0] data byte, [13:8] ignored
- port1Val  output  16  status word to port 1 (bit map below)
- txd  output  1  UART serial out, idle high

Behaviour:
- Reset (reset==0 at a clock edge): lastTog=0, FIFO empty (rd/wr ptr=0, count=0), overflow=0, FSM=IDLE, bit counter=0, clock divider=0, txd=1, port1Val=16'h0000. Reset overrides all activity, including mid-frame; the frame is abandoned with txd high on the next cycle.
- Handshake: port0Val is registered every cycle. Push request = (port0Val[15] != lastTog). On every request, lastTog <= port0Val[15] regardless of acceptance, so each toggle is a single request.
- Accept rule: push accepted if count < FIFO_DEPTH, or if the FSM pops in the same cycle. Accepted byte = port0Val[7:0] written at wr ptr; ptr wraps modulo FIFO_DEPTH.
- Rejected push (full and no pop): byte dropped, overflow <= 1.
- Overflow: sticky. Cleared by port0Val[14]==1. Clear and a new overflow in the same cycle: set wins.
- Count: +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds FIFO_DEPTH and never underflows.
- FSM states:
  - IDLE: txd=1. If count>0, pop the head into the shift register and go to START; divider=0.
  - START: txd=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: txd=shift[index], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. Then go to IDLE; IDLE pops the next byte on the following edge, so frames are separated by exactly one idle-high cycle.
- Frame length: 10*CLKS_PER_BIT cycles, plus 1 IDLE cycle between back-to-back frames.
- Latency: toggle applied before edge N is queued at edge N. FSM leaves IDLE at edge N+1, so txd falls after edge N+1.
- port1Val (registered, updates one cycle after the underlying state changes):
  - [0] busy = (FSM != IDLE) or (count != 0)
  - [1] full = (count == FIFO_DEPTH)
  - [2] overflow
  - [5:3] count
  - [15] ack = lastTog
  - all other bits 0
- Firmware rule: a new byte may be sent once port1Val[15] equals the last toggle written and full==0.

Test Plan:
- Reset: hold reset=0 for 3 cycles with port0Val=16'hFFFF -> port1Val=0, txd=1. Release with port0Val=16'h0000 -> no push, port1Val stays 0.
- Single byte: CLKS_PER_BIT=4, write 16'h80A5 -> ack bit=1 and count=1, then txd low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles. busy drops 1 cycle after STOP ends; frame totals 40 cycles.
- Fill/overflow: while the first frame is sending, toggle 5 more times with bytes 01..05 -> bytes 01..04 queued, full=1, 05 dropped, overflow=1. Subsequent frames are 01,02,03,04, each separated by 1 idle-high cycle.
- Simultaneous push and pop: with count=4, toggle on the exact cycle IDLE pops -> byte accepted, count stays 4, overflow stays 0.
- Overflow clear: with overflow=1, set port0Val[14]=1 for one cycle -> overflow=0 next cycle. Clear and rejected push in the same cycle -> overflow stays 1.
- Mid-frame reset: assert reset=0 during DATA bit 3 -> next cycle txd=1 and status 0. After release, the same toggle level produces no spurious push.
